// File: rtl/lutram_bist_sequencer.sv
// On-chip write/read-back march sequencer and checker for the XC7 LUTRAM functional test.
// Define LUTRAM_BIST_INV_PASS_EN to add a second march with inverted data.
module lutram_bist_sequencer #(
    parameter int unsigned           OP_WIDTH   = 2,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5,
    parameter int unsigned           SETTLE     = 1,
    parameter int unsigned           ERR_WIDTH  = 16
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     start_i,
    output logic [DATA_WIDTH+ADDR_WIDTH+OP_WIDTH-1:0] instr_o,
    input  logic [DATA_WIDTH-1:0]                    rdata_i,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic                                     pass_o,
    output logic [ERR_WIDTH-1:0]                     err_count_o,
    output logic [ADDR_WIDTH-1:0]                    first_fail_addr_o
);

    localparam int unsigned           CNT_WIDTH = $clog2(SETTLE + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(SETTLE);
    localparam logic [OP_WIDTH-1:0]   OP_WRITE  = '1;
    localparam logic [OP_WIDTH-1:0]   OP_READ   = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
`ifdef LUTRAM_BIST_INV_PASS_EN
        S_INV_WRITE,
        S_INV_READ,
`endif
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ERR_WIDTH-1:0]    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   ffa_q, ffa_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [DATA_WIDTH+ADDR_WIDTH+OP_WIDTH-1:0] instr_q, instr_d;
    logic                    cmp_en;
    logic                    cmp_inv;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic inv);
        logic [DATA_WIDTH-1:0] p;
        p = DATA_WIDTH'(addr) ^ SEED;
        return inv ? ~p : p;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ffa_d   = ffa_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cmp_en  = 1'b0;
        cmp_inv = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_WRITE;
                    addr_d  = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ffa_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_READ;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_READ: begin
                if (cnt_q == CNT_LAST) begin
                    cmp_en = 1'b1;
                    cnt_d  = '0;
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
`ifdef LUTRAM_BIST_INV_PASS_EN
                        state_d = S_INV_WRITE;
`else
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef LUTRAM_BIST_INV_PASS_EN
            S_INV_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_INV_READ;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_INV_READ: begin
                cmp_inv = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cmp_en = 1'b1;
                    cnt_d  = '0;
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A zero error count means no mismatch yet this run (the counter saturates, never wraps)
        if (cmp_en && (rdata_i != pattern(addr_q, cmp_inv))) begin
            if (err_q == '0) begin
                ffa_d = addr_q;
            end
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
        end

        pass_d = done_d && (err_d == '0);

        // instr is registered from next-state values so it lines up with the state it describes
        case (state_d)
            S_WRITE:     instr_d = {pattern(addr_d, 1'b0), addr_d, OP_WRITE};
            S_READ:      instr_d = {{DATA_WIDTH{1'b0}}, addr_d, OP_READ};
`ifdef LUTRAM_BIST_INV_PASS_EN
            S_INV_WRITE: instr_d = {pattern(addr_d, 1'b1), addr_d, OP_WRITE};
            S_INV_READ:  instr_d = {{DATA_WIDTH{1'b0}}, addr_d, OP_READ};
`endif
            default:     instr_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ffa_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffa_q   <= ffa_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            instr_q <= instr_d;
        end
    end

    assign instr_o           = instr_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign err_count_o       = err_q;
    assign first_fail_addr_o = ffa_q;

endmodule

// File: tb/tb_lutram_bist_sequencer.sv
// Self-checking bench for lutram_bist_sequencer: LUTRAM models with stuck-at faults and a march-level model.
module tb_lutram_bist_sequencer;

    localparam int DEPTH  = 256;
    localparam int SETTLE = 1;
    localparam logic [7:0] SEED = 8'hA5;
`ifdef LUTRAM_BIST_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [17:0] instr_a, instr_b;
    logic [7:0]  rdata_a, rdata_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] err_a;
    logic [0:0]  err_b;
    logic [7:0]  ffa_a, ffa_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] s1 [256];
    logic [7:0] s0 [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lutram_bist_sequencer #(
        .OP_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH),
        .SEED(SEED), .SETTLE(SETTLE), .ERR_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .instr_o(instr_a),
        .rdata_i(rdata_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .err_count_o(err_a), .first_fail_addr_o(ffa_a)
    );

    lutram_bist_sequencer #(
        .OP_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(DEPTH),
        .SEED(SEED), .SETTLE(SETTLE), .ERR_WIDTH(1)
    ) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .instr_o(instr_b),
        .rdata_i(rdata_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .err_count_o(err_b), .first_fail_addr_o(ffa_b)
    );

    // LUTRAMs: synchronous write, asynchronous read through per-address stuck-at masks
    always @(posedge clk) begin
        if (instr_a[1:0] == 2'b11) mem_a[instr_a[9:2]] <= instr_a[17:10];
        if (instr_b[1:0] == 2'b11) mem_b[instr_b[9:2]] <= instr_b[17:10];
    end
    assign rdata_a = (mem_a[instr_a[9:2]] | s1[instr_a[9:2]]) & ~s0[instr_a[9:2]];
    assign rdata_b = (mem_b[instr_b[9:2]] | s1[instr_b[9:2]]) & ~s0[instr_b[9:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < 256; a++) begin
            s1[a] = 8'h00;
            s0[a] = 8'h00;
        end
    endtask

    task automatic set_fault(input int a, input logic [7:0] one, input logic [7:0] zero);
        s1[a] = one;
        s0[a] = zero;
    endtask

    // March outcome derived from the fault map: every address written then read, per pass
    task automatic model(output int nerr, output int ffa);
        logic [7:0] want, seen;
        nerr = 0;
        ffa  = 0;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                want = 8'(a) ^ SEED;
                if (p == 1) want = ~want;
                seen = (want | s1[a]) & ~s0[a];
                if (seen != want) begin
                    if (nerr == 0) ffa = a;
                    nerr++;
                end
            end
        end
    endtask

    function automatic logic [17:0] exp_instr(input int c);
        int per, ph, r;
        logic [7:0] a, d;
        per = DEPTH * (SETTLE + 2);
        ph  = c / per;
        r   = c % per;
        if (r < DEPTH) begin
            a = 8'(r);
            d = 8'(r) ^ SEED;
            if (ph == 1) d = ~d;
            return {d, a, 2'b11};
        end
        a = 8'((r - DEPTH) / (SETTLE + 1));
        return {8'h00, a, 2'b00};
    endfunction

    task automatic run(input string name, input int repulse_at);
        int nerr, ffa, total, c, bad;
        model(nerr, ffa);
        total = DEPTH * (SETTLE + 2) * PASSES;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({name, "_busy_start"}, busy_a, 1);
        check({name, "_done_clr"}, done_a, 0);
        check({name, "_err_clr"}, err_a, 0);
        c   = 0;
        bad = 0;
        while (busy_a && c < total + 10) begin
            if (instr_a !== exp_instr(c)) bad++;
            start = (c == repulse_at);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check({name, "_instr_stream_bad"}, bad, 0);
        check({name, "_run_length"}, c, total);
        check({name, "_done"}, done_a, 1);
        check({name, "_instr_idle"}, instr_a, 0);
        check({name, "_pass"}, pass_a, (nerr == 0) ? 1 : 0);
        check({name, "_err"}, err_a, nerr);
        check({name, "_ffa"}, ffa_a, ffa);
        check({name, "_sat_busy"}, busy_b, 0);
        check({name, "_sat_done"}, done_b, 1);
        check({name, "_sat_err"}, err_b, (nerr > 0) ? 1 : 0);
        check({name, "_sat_ffa"}, ffa_b, ffa);
        check({name, "_sat_pass"}, pass_b, (nerr == 0) ? 1 : 0);
    endtask

    initial begin
        int n, a;
        logic [7:0] m1, m0;
        clear_faults();
        repeat (3) @(negedge clk);
        check("rst_instr", instr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_ffa", ffa_a, 0);
        rst_n = 1'b1;

        // Reset in the middle of the write phase, at address 7
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_instr_addr7", instr_a, exp_instr(7));
        rst_n = 1'b0;
        #1;
        check("mid_rst_instr", instr_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        check("mid_rst_pass", pass_a, 0);
        check("mid_rst_err", err_a, 0);
        check("mid_rst_ffa", ffa_a, 0);
        @(negedge clk);
        check("mid_rst_hold_busy", busy_a, 0);
        rst_n = 1'b1;

        run("ideal", -1);

        set_fault(8'h42, 8'h08, 8'h00);
        run("stuck1_42", -1);

        clear_faults();
        set_fault(10, 8'h00, 8'h01);
        set_fault(200, 8'h80, 8'h00);
        run("two_faults", -1);

        clear_faults();
        run("repulse", 300);
        run("rerun_done", 5);

        set_fault(8'h05, 8'h00, 8'h01);
        run("stuck0_05", -1);

        for (int r = 0; r < 3; r++) begin
            clear_faults();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                a  = $urandom_range(0, 255);
                m1 = 8'($urandom);
                m0 = 8'($urandom) & ~m1;
                set_fault(a, m1, m0);
            end
            run("random", $urandom_range(0, 700));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
